fb_hazard_fwd_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the five-stage pipeline. It tracks the destination register of every in-flight instruction from ID through WB and generates the 2-bit select codes consumed by the EX-stage operand forwarding multiplexers. The select encoding is 00 = register file, 10 = ALU result from MEM, 01 = memory or older result from WB. It also issues the load-use stall and bubble controls to the IF/ID and ID/EX pipeline registers.

---
 rtl/fb_hazard_fwd_ctrl_pkg.sv | 30 +++
 rtl/fb_fwd_cmp.sv | 28 ++
 rtl/fb_hazard_fwd_ctrl.sv | 109 ++++++++++
 tb/tb_fb_hazard_fwd_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_hazard_fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller:
// select encodings, tracker-entry layout and the writer predicate.
package fb_hazard_fwd_ctrl_pkg;

    localparam int FB_REG_AW = 5;

    localparam logic [1:0] FB_FWD_REG = 2'b00;
    localparam logic [1:0] FB_FWD_ALU = 2'b10;
    localparam logic [1:0] FB_FWD_MEM = 2'b01;

    typedef struct packed {
        logic                 valid;
        logic [FB_REG_AW-1:0] rd;
        logic                 regwrite;
        logic                 is_load;
    } fb_entry_t;

    localparam fb_entry_t FB_ENTRY_NONE = '{
        valid:    1'b0,
        rd:       {FB_REG_AW{1'b0}},
        regwrite: 1'b0,
        is_load:  1'b0
    };

    // x0 is hardwired to zero, so an entry targeting it never produces a value.
    function automatic logic fb_is_writer(input fb_entry_t e);
        return e.valid & e.regwrite & (e.rd != {FB_REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/fb_fwd_cmp.sv
// Per-operand forwarding comparator: picks the youngest in-flight producer of
// the incoming ID source register relative to the entries it is about to pass.
module fb_fwd_cmp
    import fb_hazard_fwd_ctrl_pkg::*;
(
    input  logic [FB_REG_AW-1:0] rs,
    input  logic                 used,
    input  fb_entry_t            ex_e,
    input  fb_entry_t            mem_e,
    output logic [1:0]           sel
);

    logic mem_load_unused_s;
    assign mem_load_unused_s = mem_e.is_load;

    // A load in EX never feeds the ALU path; the stall inserts a bubble first.
    always_comb begin
        sel = FB_FWD_REG;
        if (used && fb_is_writer(ex_e) && !ex_e.is_load && (rs == ex_e.rd)) begin
            sel = FB_FWD_ALU;
        end else if (used && fb_is_writer(mem_e) && (rs == mem_e.rd)) begin
            sel = FB_FWD_MEM;
        end else begin
            sel = FB_FWD_REG;
        end
    end

endmodule

// File: rtl/fb_hazard_fwd_ctrl.sv
// Tracks destinations of in-flight instructions (EX/MEM/WB), produces registered
// EX operand forwarding selects and the combinational load-use stall/bubble.
module fb_hazard_fwd_ctrl
    import fb_hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = FB_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              ext_stall,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if_id,
    output logic              bubble_ex
);

    fb_entry_t  ex_r;
    fb_entry_t  mem_r;
    fb_entry_t  wb_r;
    fb_entry_t  ex_next_s;
    logic       hazard_s;
    logic       load_use_s;
    logic [1:0] sel_a_s;
    logic [1:0] sel_b_s;
    logic [1:0] fwd_a_r;
    logic [1:0] fwd_b_r;

    // WB is tracked for pipeline bookkeeping; WB->ID reads use the regfile bypass.
    logic wb_unused_s;
    assign wb_unused_s = ^wb_r;

    fb_fwd_cmp u_cmp_a (
        .rs    (id_rs1),
        .used  (id_rs1_used),
        .ex_e  (ex_r),
        .mem_e (mem_r),
        .sel   (sel_a_s)
    );

    fb_fwd_cmp u_cmp_b (
        .rs    (id_rs2),
        .used  (id_rs2_used),
        .ex_e  (ex_r),
        .mem_e (mem_r),
        .sel   (sel_b_s)
    );

    // Load-use detection; flush and the global freeze both suppress the stall.
    always_comb begin
        hazard_s = fb_is_writer(ex_r) & ex_r.is_load & id_valid &
                   ((id_rs1_used & (id_rs1 == ex_r.rd)) |
                    (id_rs2_used & (id_rs2 == ex_r.rd)));
        if (hazard_s && !ext_stall && !flush) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Next EX entry: the ID instruction unless it is bubbled or flushed.
    always_comb begin
        ex_next_s = FB_ENTRY_NONE;
        if (load_use_s || flush) begin
            ex_next_s = FB_ENTRY_NONE;
        end else begin
            ex_next_s.valid    = id_valid;
            ex_next_s.rd       = id_rd;
            ex_next_s.regwrite = id_regwrite;
            ex_next_s.is_load  = id_is_load;
        end
    end

    // Tracker advance and select registers; everything holds during ext_stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_r    <= FB_ENTRY_NONE;
            mem_r   <= FB_ENTRY_NONE;
            wb_r    <= FB_ENTRY_NONE;
            fwd_a_r <= FB_FWD_REG;
            fwd_b_r <= FB_FWD_REG;
        end else if (!ext_stall) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= ex_next_s;
            if (load_use_s || flush) begin
                fwd_a_r <= FB_FWD_REG;
                fwd_b_r <= FB_FWD_REG;
            end else begin
                fwd_a_r <= sel_a_s;
                fwd_b_r <= sel_b_s;
            end
        end
    end

    assign fwd_a_sel   = fwd_a_r;
    assign fwd_b_sel   = fwd_b_r;
    assign stall_if_id = load_use_s;
    assign bubble_ex   = load_use_s;

endmodule

// File: tb/tb_fb_hazard_fwd_ctrl.sv
// Directed self-checking bench for fb_hazard_fwd_ctrl: instruction sequences
// with hand-computed forwarding selects and stall/bubble expectations.
module tb_fb_hazard_fwd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_is_load;
    logic       ext_stall;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall_if_id;
    logic       bubble_ex;

    int checks;
    int errors;

    fb_hazard_fwd_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .ext_stall   (ext_stall),
        .flush       (flush),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic ld);
        id_valid    = v;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ext_stall = 1'b0;
        flush = 1'b0;
        nop();
        cycle();
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if ({stall_if_id, bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall: got stall=%b bubble=%b expected 0 0", stall_if_id, bubble_ex);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_alu_b2b();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        checks++;
        if (stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got %b expected 0", stall_if_id);
        end
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_sel: got a=%b b=%b expected 10 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_distance_two();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        nop();
        cycle();
        set_id(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin
            errors++;
            $display("FAIL dist2_sel: got a=%b b=%b expected 00 01", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_double_producer();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
            errors++;
            $display("FAIL double_sel: got a=%b b=%b expected 10 10", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        drain();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++;
        if ({stall_if_id, bubble_ex} !== 2'b11) begin
            errors++;
            $display("FAIL lu_stall: got stall=%b bubble=%b expected 1 1", stall_if_id, bubble_ex);
        end
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL lu_bubble_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        checks++;
        if ({stall_if_id, bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL lu_stall_clear: got stall=%b bubble=%b expected 0 0", stall_if_id, bubble_ex);
        end
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
            errors++;
            $display("FAIL lu_sel: got a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_x0_unused();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL x0_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0);
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL unused_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        drain();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
        checks++;
        if ({stall_if_id, bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL x0_load_stall: got stall=%b bubble=%b expected 0 0", stall_if_id, bubble_ex);
        end
    endtask

    task automatic test_flush();
        drain();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if ({stall_if_id, bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL flush_stall: got stall=%b bubble=%b expected 0 0", stall_if_id, bubble_ex);
        end
        cycle();
        flush = 1'b0;
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL flush_sel: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
        // EX is now empty and the load sits in MEM: no stall, forward from WB path.
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        checks++;
        if (stall_if_id !== 1'b0) begin
            errors++;
            $display("FAIL flush_ex_zero_stall: got %b expected 0", stall_if_id);
        end
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
            errors++;
            $display("FAIL flush_ex_zero_sel: got a=%b b=%b expected 01 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_ext_stall();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        ext_stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if ({fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex} !== 6'b100000) begin
                errors++;
                $display("FAIL ext_stall_hold[%0d]: got a=%b b=%b stall=%b bubble=%b expected 10 00 0 0",
                         i, fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex);
            end
        end
        ext_stall = 1'b0;
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0110) begin
            errors++;
            $display("FAIL ext_stall_release: got a=%b b=%b expected 01 10", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        cycle();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        cycle();
        set_id(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0);
        rst_n = 1'b0;
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_mid: got a=%b b=%b stall=%b bubble=%b expected all 0",
                     fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex);
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_cleared: got a=%b b=%b expected 00 00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_b2b();
        test_distance_two();
        test_double_producer();
        test_load_use();
        test_x0_unused();
        test_flush();
        test_ext_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
